// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It inhibits the bus, issues request-to-send,
// shifts a byte on device clock edges, captures the ACK and aborts on timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned REQ_CYCLES     = 16,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned XFER_TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, WAIT_START, SHIFT, WAIT_ACK, WAIT_IDLE, ABORT
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [3:0]  idx, idx_n;
  logic [9:0]  frame, frame_n;
  logic        ack_pend, ack_pend_n;
  logic [2:0]  s_clk;
  logic [1:0]  s_data;
  logic        sync_clk, sync_data, fe;
  logic        start_to, xfer_to;
  logic        clk_oe_n, data_oe_n, busy_n, tx_ready_n, done_n, ack_ok_n, err_n;

  assign sync_clk  = s_clk[1];
  assign sync_data = s_data[1];
  assign fe        = s_clk[2] & ~s_clk[1];

  // Abort is decided two counts early: the ABORT cycle plus the registered
  // err then land exactly TIMEOUT cycles after the phase start.
  assign start_to = (cnt == 32'(START_TIMEOUT - 2));
  assign xfer_to  = (cnt == 32'(XFER_TIMEOUT - 2));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 32'd1;
    idx_n      = idx;
    frame_n    = frame;
    ack_pend_n = ack_pend;
    data_oe_n  = ps2_data_oe;
    done_n     = 1'b0;
    err_n      = 1'b0;
    ack_ok_n   = ack_ok;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid && tx_ready) begin
          frame_n = {1'b1, ~^tx_data, tx_data};
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == 32'(INHIBIT_CYCLES - 1)) begin
          state_n = REQ;
          cnt_n   = '0;
        end
      end
      REQ: begin
        if (cnt == 32'(REQ_CYCLES - 1)) begin
          state_n = WAIT_START;
          cnt_n   = '0;
        end
      end
      WAIT_START: begin
        if (start_to) begin
          state_n = ABORT;
        end else if (fe) begin
          data_oe_n = ~frame[0];
          idx_n     = 4'd1;
          cnt_n     = 32'd1;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer_to) begin
          state_n = ABORT;
        end else if (fe) begin
          data_oe_n = ~frame[idx];
          idx_n     = idx + 4'd1;
          if (idx == 4'd9) state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (xfer_to) begin
          state_n = ABORT;
        end else if (fe) begin
          ack_pend_n = ~sync_data;
          state_n    = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (xfer_to) begin
          state_n = ABORT;
        end else if (sync_clk && sync_data) begin
          done_n   = 1'b1;
          ack_ok_n = ack_pend;
          state_n  = IDLE;
        end
      end
      ABORT: begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    clk_oe_n   = (state_n == INHIBIT) || (state_n == REQ);
    busy_n     = (state_n != IDLE);
    tx_ready_n = (state_n == IDLE);
    if (state_n == IDLE || state_n == INHIBIT || state_n == ABORT) data_oe_n = 1'b0;
    if (state_n == REQ) data_oe_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      frame       <= '0;
      ack_pend    <= 1'b0;
      s_clk       <= '0;
      s_data      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      frame       <= frame_n;
      ack_pend    <= ack_pend_n;
      s_clk       <= {s_clk[1:0], ps2_clk_in};
      s_data      <= {s_data[0], ps2_data_in};
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      tx_ready    <= tx_ready_n;
      done        <= done_n;
      ack_ok      <= ack_ok_n;
      err         <= err_n;
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: serialises one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same open-collector PS2_CLK/PS2_DATA pair that KeyboardDecoder receives on. It performs bus inhibit, request-to-send, 10 device-clocked bits, ACK capture and timeout recovery. It sits beside KeyboardDecoder in TOP; the top level builds the tri-states from the `*_oe` outputs, and `busy` gates the receiver.

## Interface
- INHIBIT_CYCLES, 12000: clk cycles PS2_CLK is held low (120 µs at 100 MHz).
- REQ_CYCLES, 16: clk cycles both lines are held low before PS2_CLK is released.
- START_TIMEOUT, 1500000: max cycles from PS2_CLK release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 200000: max cycles from the first falling edge to bus-idle (2 ms).
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready at a posedge.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
- ps2_data_in  in  1  raw PS2_DATA pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- ack_ok  out  1  ACK result of the last completed transfer; held until the next done.
- err  out  1  one-cycle pulse on a timeout abort.

## Operation
- ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
- A registered copy of the synchronised clock gives the falling-edge strobe `fe` (sync clock 1→0).
- The byte is latched on accept. Parity is odd: par = ~^tx_data.
- FSM states and behaviour:
  - IDLE: both oe = 0, tx_ready = 1; go to INHIBIT on accept.
  - INHIBIT: clk_oe = 1, data_oe = 0, for INHIBIT_CYCLES cycles; then REQ.
  - REQ: clk_oe = 1, data_oe = 1 (start bit), for REQ_CYCLES cycles; then WAIT_START.
  - WAIT_START: clk_oe = 0, data_oe = 1; start the timeout counter.
    - On fe: go to SHIFT with bit index 0 and reset the counter for XFER_TIMEOUT.
    - On count = START_TIMEOUT: ABORT.
  - SHIFT: on each fe, drive data_oe = ~bit for the sequence d0..d7, par, stop (stop = release, data_oe = 0).
    - The 1st fe presents d0, the 9th presents par, the 10th releases data. Then WAIT_ACK.
  - WAIT_ACK: on the 11th fe, ack_ok_next = ~sync_data (data low = ACK); go to WAIT_IDLE.
  - WAIT_IDLE: wait until sync clock = 1 and sync data = 1 on the same cycle; then pulse done, update ack_ok, go to IDLE.
  - ABORT: 1 cycle; both oe = 0, err = 1; then IDLE. ack_ok is unchanged.
- The XFER_TIMEOUT count runs through SHIFT, WAIT_ACK and WAIT_IDLE. Reaching XFER_TIMEOUT in any of those states goes to ABORT.
- tx_valid while busy is ignored; no queueing.
- A missing ACK is not an error: done pulses with ack_ok = 0.

## Timing
- Reset (rst = 0): all outputs 0 immediately, including both oe, so the bus is released mid-transfer. State goes to IDLE, counters and synchronisers clear. tx_ready = 1 from the first clk edge after rst deasserts.
- Accept at edge T: tx_ready = 0, busy = 1, clk_oe = 1 from T+1.
- data_oe = 1 from T+1+INHIBIT_CYCLES.
- clk_oe = 0 from T+1+INHIBIT_CYCLES+REQ_CYCLES.
- Pin falling edge to data_oe update: 3 clk cycles (2 sync + 1 edge detect). This is well within the device's clock-low half period (≥30 µs).
- done or err: 1 cycle wide, coincident with the transition into IDLE. tx_ready = 1 in that same cycle.
- fe on the exact cycle the timeout count is reached: the timeout wins (ABORT).
- All outputs are registered; no combinational path from pins to outputs.

## Test plan
- Device model with ACK, tx_data = 0xED: the 10 bit values seen by the device on rising edges are 1,0,1,1,0,1,1,1, par = 1, stop = 1. Then done = 1 for one cycle, ack_ok = 1, tx_ready = 1.
- Inhibit/request timing with INHIBIT_CYCLES = 50, REQ_CYCLES = 4: clk_oe is high for exactly 54 cycles, data_oe rises 50 cycles after accept, and clk_oe falls with data_oe still 1.
- tx_data = 0x01 with the device leaving data high at the 11th edge: parity bit 0 is observed, then done = 1 and ack_ok = 0. A later 0xFF transfer with ACK gives parity 1 and ack_ok = 1.
- No device clock, START_TIMEOUT = 1000: err pulses exactly 1000 cycles after clk_oe falls, both oe = 0, done never asserts, and the next accept works.
- Device stops after 5 falling edges, XFER_TIMEOUT = 500: err pulses 500 cycles after the first fe and data_oe = 0. tx_valid asserted during the transfer is not accepted.
- rst driven low during the SHIFT state: ps2_clk_oe, ps2_data_oe, busy and done are 0 in the same cycle without waiting for a clk edge. After release, a fresh 0xF4 transfer completes with ack_ok = 1.
